breath_ramp: RTL and testbench
==============================

# breath_ramp

Upstream duty-ramp generator for the LED breathing path. It produces a free-running PWM carrier count and a triangular duty threshold that rises from 0 to `LENGTH`, holds, falls back to 0, and holds again. The downstream comparator stage drives `led = (pwm_cnt < duty)`. Duty changes only on carrier period boundaries, so the LED never sees a truncated or glitched PWM period.

## Interface

Parameters:
- `LENGTH`, 30: carrier period in clocks. `pwm_cnt` runs 0..LENGTH-1. Duty range is 0..LENGTH. Legal values ≥ 2.
- `STEP_DIV`, 300: carrier periods per duty step, i.e. the ramp slow-down factor. Legal values ≥ 1.
- `HOLD`, 2: duty steps held at each extreme (top and bottom). 0 skips the hold states.

Ports:
- `clk` input, 1: single clock.
- `rst` input, 1: reset, synchronous, active-high.
- `en` input, 1: advance enable. When low, all state freezes.
- `pwm_cnt` output, 32: carrier count, fed to the comparator.
- `duty` output, 32: current threshold, fed to the comparator.
- `period_start` output, 1: one-cycle pulse in the cycle where `pwm_cnt` reads 0 after a wrap.
- `dir` output, 1: 1 in rising/top-hold, 0 in falling/bottom-hold.

## Operation

**Reset:**
- Outputs: `pwm_cnt`=0, `duty`=0, `period_start`=0, `dir`=1.
- Internal: state=UP, period divider `div_cnt`=0, `hold_cnt`=0.
- `rst` has priority over `en` in every cycle, including mid-ramp and mid-hold.

**Carrier:**
- Counts only while `en`=1.
- At `LENGTH-1` it wraps to 0.
- `period_start` is registered and asserted exactly in the cycle `pwm_cnt`=0 following a wrap.
- `period_start` is not asserted in the first cycle after reset.

**Divider:**
- `div_cnt` increments on each carrier wrap and wraps at `STEP_DIV-1`.
- A step event occurs when `en` && `pwm_cnt`=LENGTH-1 && `div_cnt`=STEP_DIV-1.

**FSM:** Evaluated only on step events; states UP, TOP, DOWN, BOT.
- **UP:** `duty`+1. If the new value = LENGTH, go to TOP (HOLD>0) or DOWN (HOLD=0).
- **TOP:** `hold_cnt`+1. At `hold_cnt`=HOLD-1, clear `hold_cnt` and go to DOWN.
- **DOWN:** `duty`-1. If the new value = 0, go to BOT (HOLD>0) or UP (HOLD=0).
- **BOT:** same as TOP, then go to UP.
- `dir` is registered and updated together with the state.

**Arithmetic:**
- All counters are 32-bit unsigned.
- `duty` never leaves 0..LENGTH; no wrap below 0 or above LENGTH.

**en deassertion:**
- Freezes `pwm_cnt`, `div_cnt`, `hold_cnt`, state and `duty`.
- Forces `period_start`=0.
- Resuming continues from the frozen values with no lost or duplicated step.

## Timing

- All outputs are registered. No combinational path from `en` to any output.
- A step event in cycle t gives, in cycle t+1: `pwm_cnt`=0, new `duty`, new `dir`, `period_start`=1.
- Carrier period: LENGTH clocks.
- Step interval: STEP_DIV·LENGTH clocks.
- Full breath cycle: (2·LENGTH + 2·HOLD)·STEP_DIV·LENGTH clocks with `en` held high.
- First duty change after reset (`en`=1 from cycle 0) appears at clock STEP_DIV·LENGTH.

## Structure

- Shared package `breath_pkg`:
  - state enum (UP, TOP, DOWN, BOT)
  - counter width constant (32)
- Sub-module `pwm_carrier`:
  - contains the carrier counter and `period_start` register
  - exports a `wrap` strobe for the divider
- Divider, FSM and duty register live in `breath_ramp`.

## Test plan

All scenarios use LENGTH=4, STEP_DIV=2, HOLD=1, `en`=1 unless noted.

1. **Reset then run 8 clocks:** `pwm_cnt` sequence is 0,1,2,3,0,1,2,3; `duty`=0 throughout; `period_start` high only at clock 4; clock 8 gives `duty`=1 with `period_start`=1.
2. **Full cycle, 80 clocks:** `duty` steps 1,2,3,4, holds 4 for one step, then 3,2,1,0, holds 0 for one step. `dir` falls when entering DOWN and rises when entering UP. Values repeat identically over the next 80 clocks.
3. **`en` low for 5 clocks at `pwm_cnt`=3, `div_cnt`=1:** all outputs frozen and `period_start`=0. After re-enable the step occurs on the very next cycle with `duty`+1.
4. **`rst` pulsed while `duty`=4 in TOP:** next cycle `pwm_cnt`=0, `duty`=0, `dir`=1, `period_start`=0. Ramp restarts and the first step lands 8 clocks later.
5. **HOLD=0:** `duty` goes 3→4→3 and 1→0→1 on consecutive steps. Full cycle is 64 clocks.
6. **Comparator check with a bench model `led=pwm_cnt<duty`:** `duty`=0 gives `led` always 0; `duty`=4 gives `led` always 1; within every carrier period the high-time equals `duty`.

Source files
------------

// File: rtl/breath_pkg.sv
// Shared types and widths for the LED breathing duty-ramp path.
package breath_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {UP, TOP, DOWN, BOT} state_t;

endpackage

// File: rtl/breath_ramp_if.sv
// Bundle between the duty-ramp generator and the downstream PWM comparator.
interface breath_ramp_if;
  import breath_pkg::*;

  logic             en;
  logic [CNT_W-1:0] pwm_cnt;
  logic [CNT_W-1:0] duty;
  logic             period_start;
  logic             dir;

  modport master (output en, input pwm_cnt, duty, period_start, dir);
  modport slave  (input en, output pwm_cnt, duty, period_start, dir);

endinterface

// File: rtl/pwm_carrier.sv
// Free-running PWM carrier counter with a registered period-start pulse
// and a combinational wrap strobe for the step divider.
module pwm_carrier
  import breath_pkg::*;
#(
  parameter int unsigned LENGTH = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] pwm_cnt,
  output logic             period_start,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LENGTH - 1);

  assign wrap = en && (pwm_cnt == LAST);

  // period_start follows wrap so it reads high exactly while pwm_cnt shows 0
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt      <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (en) begin
        pwm_cnt <= wrap ? '0 : pwm_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/breath_ramp.sv
// Triangular duty ramp (rise, top hold, fall, bottom hold) that only changes
// on carrier period boundaries so the LED never sees a truncated period.
module breath_ramp
  import breath_pkg::*;
#(
  parameter int unsigned LENGTH   = 30,
  parameter int unsigned STEP_DIV = 300,
  parameter int unsigned HOLD     = 2
) (
  input  logic          clk,
  input  logic          rst,
  breath_ramp_if.slave  bus
);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] TOP_VAL   = CNT_W'(LENGTH);
  localparam bit               HAS_HOLD  = (HOLD > 0);

  logic             wrap;
  logic             step;
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nxt;
  logic [CNT_W-1:0] duty_nxt;
  logic             dir_nxt;
  state_t           state;
  state_t           state_nxt;

  pwm_carrier #(.LENGTH(LENGTH)) u_carrier (
    .clk          (clk),
    .rst          (rst),
    .en           (bus.en),
    .pwm_cnt      (bus.pwm_cnt),
    .period_start (bus.period_start),
    .wrap         (wrap)
  );

  assign step = wrap && (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (wrap) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= UP;
      bus.duty <= '0;
      bus.dir  <= 1'b1;
      hold_cnt <= '0;
    end else if (step) begin
      state    <= state_nxt;
      bus.duty <= duty_nxt;
      bus.dir  <= dir_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    duty_nxt  = bus.duty;
    hold_nxt  = hold_cnt;
    case (state)
      UP: begin
        duty_nxt = bus.duty + CNT_W'(1);
        if (duty_nxt == TOP_VAL) state_nxt = HAS_HOLD ? TOP : DOWN;
      end
      TOP: begin
        if (hold_cnt == HOLD_LAST) begin
          hold_nxt  = '0;
          state_nxt = DOWN;
        end else begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      DOWN: begin
        duty_nxt = bus.duty - CNT_W'(1);
        if (duty_nxt == '0) state_nxt = HAS_HOLD ? BOT : UP;
      end
      BOT: begin
        if (hold_cnt == HOLD_LAST) begin
          hold_nxt  = '0;
          state_nxt = UP;
        end else begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = UP;
    endcase
    dir_nxt = (state_nxt == UP) || (state_nxt == TOP);
  end

endmodule

// File: tb/tb_breath_ramp.sv
// Scoreboard bench for breath_ramp: two instances (HOLD=1 and HOLD=0) checked
// against a closed-form triangle model driven by randomized en/rst.
module tb_breath_ramp;

  localparam int unsigned L  = 4;
  localparam int unsigned SD = 2;

  typedef struct {
    logic [31:0] pwm;
    logic [31:0] duty;
    logic        ps;
    logic        dir;
    logic        led;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  int unsigned n_en   = 0;
  logic        ps_exp = 1'b0;

  exp_t q_h1[$];
  exp_t q_h0[$];

  breath_ramp_if bus_h1();
  breath_ramp_if bus_h0();

  breath_ramp #(.LENGTH(L), .STEP_DIV(SD), .HOLD(1)) dut_h1 (
    .clk (clk),
    .rst (rst),
    .bus (bus_h1)
  );

  breath_ramp #(.LENGTH(L), .STEP_DIV(SD), .HOLD(0)) dut_h0 (
    .clk (clk),
    .rst (rst),
    .bus (bus_h0)
  );

  always #5 clk = ~clk;

  // Outputs after n enabled clocks since reset, derived from the triangle
  // shape: k completed steps, position p within one breath of 2L+2H steps.
  function automatic exp_t model(input int unsigned n, input logic ps,
                                 input int unsigned hold);
    exp_t        e;
    int unsigned k;
    int unsigned p;
    int unsigned per;
    per    = 2 * L + 2 * hold;
    k      = n / (SD * L);
    e.pwm  = n % L;
    e.ps   = ps;
    if (k == 0) begin
      e.duty = 0;
      e.dir  = 1'b1;
    end else begin
      p = (k - 1) % per;
      if (p < L)                 e.duty = p + 1;
      else if (p < L + hold)     e.duty = L;
      else if (p < 2 * L + hold) e.duty = 2 * L + hold - 1 - p;
      else                       e.duty = 0;
      e.dir = (p + 1 < L + hold) || (p == per - 1);
    end
    e.led = (e.pwm < e.duty);
    return e;
  endfunction

  task automatic applyStimulus(input logic r, input logic e);
    @(negedge clk);
    rst       = r;
    bus_h1.en = e;
    bus_h0.en = e;
    if (r) begin
      n_en   = 0;
      ps_exp = 1'b0;
    end else if (e) begin
      n_en   = n_en + 1;
      ps_exp = ((n_en % L) == 0);
    end else begin
      ps_exp = 1'b0;
    end
    q_h1.push_back(model(n_en, ps_exp, 1));
    q_h0.push_back(model(n_en, ps_exp, 0));
  endtask

  task automatic checkField(input string name, input logic [31:0] act,
                            input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d got=%0d expected=%0d", name, cycle, act, req);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e,
                             input logic [31:0] pwm, input logic [31:0] duty,
                             input logic ps, input logic dir);
    checkField({tag, ".pwm_cnt"}, pwm, e.pwm);
    checkField({tag, ".duty"}, duty, e.duty);
    checkField({tag, ".period_start"}, 32'(ps), 32'(e.ps));
    checkField({tag, ".dir"}, 32'(dir), 32'(e.dir));
    checkField({tag, ".led"}, 32'(pwm < duty), 32'(e.led));
  endtask

  // Monitor: every clock the DUTs present fresh registered outputs
  initial begin
    exp_t e;
    @(negedge clk);
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (q_h1.size() > 0) begin
        e = q_h1.pop_front();
        checkOutput("h1", e, bus_h1.pwm_cnt, bus_h1.duty, bus_h1.period_start, bus_h1.dir);
      end
      if (q_h0.size() > 0) begin
        e = q_h0.pop_front();
        checkOutput("h0", e, bus_h0.pwm_cnt, bus_h0.duty, bus_h0.period_start, bus_h0.dir);
      end
    end
  end

  initial begin
    bus_h1.en = 1'b0;
    bus_h0.en = 1'b0;
    $display("[TB] breath_ramp L=%0d STEP_DIV=%0d", L, SD);

    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);

    // Two full breaths of free running
    for (int i = 0; i < 170; i++) applyStimulus(1'b0, 1'b1);

    // Freeze right before a step event, then resume
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1);

    // Reset while the HOLD=1 instance sits at the top
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 34; i++) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 399) == 0), ($urandom_range(0, 7) != 0));
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if ((q_h1.size() != 0) || (q_h0.size() != 0)) begin
      failures++;
      $display("[TB] FAIL drain got=%0d/%0d pending expected=0", q_h1.size(), q_h0.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
